// File: rtl/dct_mac_sequencer.sv
// Control sequencer for one dct_unit MAC lane: term select, product/accumulator enables,
// result valid with back-pressure and per-block row tracking. Optional DCT_SEQ_STALL_CNT_EN adds stall_cnt.
module dct_mac_sequencer #(
  parameter int TERMS = 8,
  parameter int ROWS  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       din_vld,
  output logic                       din_rdy,
  output logic [$clog2(TERMS)-1:0]   coef_sel,
  output logic                       mult_ena,
  output logic                       acc_clr,
  output logic                       acc_ena,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic [$clog2(ROWS)-1:0]    row_idx,
  output logic                       blk_done,
  output logic                       busy
`ifdef DCT_SEQ_STALL_CNT_EN
  ,output logic [15:0]               stall_cnt
`endif
);

  localparam int TW = $clog2(TERMS);
  localparam int RW = $clog2(ROWS);
  localparam logic [TW-1:0] T_LAST = TW'(TERMS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [RW-1:0]   row_q, row_d;
  logic            s1_vld_q, s1_vld_d;
  logic            s1_first_q, s1_first_d;
  logic            s1_last_q, s1_last_d;
  logic            dout_vld_q, dout_vld_d;
  logic            blk_done_q, blk_done_d;
  logic            stall, accept, handshake, in_flight;

  // A pending result that downstream refuses freezes every stage.
  always_comb begin
    stall     = dout_vld_q & ~dout_rdy;
    din_rdy   = ~stall & ~clr;
    accept    = din_vld & din_rdy;
    mult_ena  = accept;
    acc_ena   = s1_vld_q & ~stall;
    acc_clr   = acc_ena & s1_first_q;
    handshake = dout_vld_q & dout_rdy;
  end

  always_comb begin
    t_d        = t_q;
    row_d      = row_q;
    s1_vld_d   = s1_vld_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    dout_vld_d = dout_vld_q;
    blk_done_d = 1'b0;
    if (accept) t_d = (t_q == T_LAST) ? '0 : t_q + 1'b1;
    if (!stall) begin
      s1_vld_d   = accept;
      s1_first_d = (t_q == '0);
      s1_last_d  = (t_q == T_LAST);
    end
    // A new last term landing in the handshake cycle keeps dout_vld high.
    if (acc_ena && s1_last_q) dout_vld_d = 1'b1;
    else if (handshake)       dout_vld_d = 1'b0;
    if (handshake) begin
      row_d      = (row_q == R_LAST) ? '0 : row_q + 1'b1;
      blk_done_d = (row_q == R_LAST);
    end
    if (clr) begin
      t_d        = '0;
      row_d      = '0;
      s1_vld_d   = 1'b0;
      s1_first_d = 1'b0;
      s1_last_d  = 1'b0;
      dout_vld_d = 1'b0;
      blk_done_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_flight = (t_d != '0) | s1_vld_d | dout_vld_d;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (stall) state_d = HOLD;
               else if (!in_flight) state_d = IDLE;
      HOLD:    if (handshake) state_d = in_flight ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      t_q        <= '0;
      row_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      dout_vld_q <= 1'b0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      row_q      <= row_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      dout_vld_q <= dout_vld_d;
      blk_done_q <= blk_done_d;
    end
  end

  assign coef_sel = t_q;
  assign row_idx  = row_q;
  assign dout_vld = dout_vld_q;
  assign blk_done = blk_done_q;
  assign busy     = (state_q != IDLE);

`ifdef DCT_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr)                                  stall_cnt_d = '0;
    else if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
